// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter for a transaction in flight; flags the last allowed cycle before abort.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (reset || clr)
      count <= 8'd0;
    else if (en)
      count <= count + 8'd1;
  end

  assign expired = (count == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and data load/store (port 1); one transaction in flight, ack or timeout always ends it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_we1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_memaccess,
  output logic [ADDR_W-1:0] o_memaddr,
  output logic              o_memwe,
  output logic [DATA_W-1:0] o_memwdata,
  input  logic [DATA_W-1:0] i_memrdata,
  input  logic              i_memack
);

  state_t            state, state_n;
  logic              last, last_n;
  logic              owner, owner_n;
  logic              grant;
  logic              memaccess_n, memwe_n, ack0_n, ack1_n, err_n;
  logic [ADDR_W-1:0] memaddr_n;
  logic [DATA_W-1:0] memwdata_n, rdata_n;
  logic              tmr_clr, tmr_en, tmr_expired;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk   (i_clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Tie goes to the port not served last; a lone request wins outright.
  assign grant = (i_req0 && i_req1) ? ~last : i_req1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    last_n      = last;
    owner_n     = owner;
    memaccess_n = o_memaccess;
    memaddr_n   = o_memaddr;
    memwe_n     = o_memwe;
    memwdata_n  = o_memwdata;
    rdata_n     = o_rdata;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    err_n       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          owner_n     = grant;
          last_n      = grant;
          memaccess_n = 1'b1;
          memaddr_n   = (grant == PORT_DATA) ? i_addr1 : i_addr0;
          memwe_n     = (grant == PORT_DATA) && i_we1;
          memwdata_n  = (grant == PORT_DATA) ? i_wdata1 : '0;
          tmr_clr     = 1'b1;
          state_n     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_memack || tmr_expired) begin
          memaccess_n = 1'b0;
          rdata_n     = (i_memack && !o_memwe) ? i_memrdata : '0;
          err_n       = !i_memack;
          ack0_n      = (owner == PORT_FETCH);
          ack1_n      = (owner == PORT_DATA);
          state_n     = ST_RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      owner       <= PORT_FETCH;
      o_memaccess <= 1'b0;
      o_memaddr   <= '0;
      o_memwe     <= 1'b0;
      o_memwdata  <= '0;
      o_rdata     <= '0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      owner       <= owner_n;
      o_memaccess <= memaccess_n;
      o_memaddr   <= memaddr_n;
      o_memwe     <= memwe_n;
      o_memwdata  <= memwdata_n;
      o_rdata     <= rdata_n;
      o_ack0      <= ack0_n;
      o_ack1      <= ack1_n;
      o_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// fairness, timeout and reset during a transaction.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req0 = 1'b0, i_req1 = 1'b0, i_we1 = 1'b0, i_memack = 1'b0;
  logic [31:0] i_addr0 = '0, i_addr1 = '0, i_wdata1 = '0, i_memrdata = '0;
  logic        o_ack0, o_ack1, o_err, o_memaccess, o_memwe;
  logic [31:0] o_rdata, o_memaddr, o_memwdata;

  int n_vec  = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_req0      (i_req0),
    .i_addr0     (i_addr0),
    .i_req1      (i_req1),
    .i_addr1     (i_addr1),
    .i_we1       (i_we1),
    .i_wdata1    (i_wdata1),
    .o_ack0      (o_ack0),
    .o_ack1      (o_ack1),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_memaccess (o_memaccess),
    .o_memaddr   (o_memaddr),
    .o_memwe     (o_memwe),
    .o_memwdata  (o_memwdata),
    .i_memrdata  (i_memrdata),
    .i_memack    (i_memack)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        rst, req0, req1, we1, memack;
    logic [31:0] addr0, addr1, wdata1, memrdata;
    logic        ack0, ack1, err, memaccess, memwe;
    logic [31:0] memaddr, memwdata, rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic rst, logic req0, logic [31:0] addr0,
                              logic req1, logic [31:0] addr1, logic we1, logic [31:0] wdata1,
                              logic memack, logic [31:0] memrdata,
                              logic ack0, logic ack1, logic err, logic memaccess,
                              logic [31:0] memaddr, logic memwe, logic [31:0] memwdata,
                              logic [31:0] rdata);
    vec_t v;
    v.name = name; v.rst = rst; v.req0 = req0; v.addr0 = addr0; v.req1 = req1;
    v.addr1 = addr1; v.we1 = we1; v.wdata1 = wdata1; v.memack = memack;
    v.memrdata = memrdata; v.ack0 = ack0; v.ack1 = ack1; v.err = err;
    v.memaccess = memaccess; v.memaddr = memaddr; v.memwe = memwe;
    v.memwdata = memwdata; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Steps until memaccess rises; a bounded wait that counts as a miscompare on expiry.
  task automatic wait_access(string name);
    for (int k = 0; k < 10 && !o_memaccess; k++) step();
    check({name, "_access_seen"}, 32'(o_memaccess), 32'd1);
  endtask

  initial begin
    //          name          rst rq0 addr0     rq1 addr1  we wdata  mack rdata        ack0 ack1 err acc addr     we wdata  rdata
    tbl.push_back(mk("reset",     1, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("rd0_grant", 0, 1, 32'h100, 0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 1, 32'h100, 0, 32'h0,  32'h0));
    tbl.push_back(mk("rd0_wait",  0, 1, 32'h100, 0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 1, 32'h100, 0, 32'h0,  32'h0));
    tbl.push_back(mk("rd0_ack",   0, 1, 32'h100, 0, 32'h0,  0, 32'h0,  1, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0,   0, 32'h0,  32'hDEADBEEF));
    tbl.push_back(mk("rd0_resp",  0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("stray_ack", 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  1, 32'h1234,     0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("stray_idle",0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("reset2",    1, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("tie_grant", 0, 1, 32'h10,  1, 32'h20, 1, 32'h55, 0, 32'h0,        0, 0, 0, 1, 32'h10,  0, 32'h0,  32'h0));
    tbl.push_back(mk("tie_ack0",  0, 1, 32'h10,  1, 32'h20, 1, 32'h55, 1, 32'hAAAA0000, 1, 0, 0, 0, 32'h0,   0, 32'h0,  32'hAAAA0000));
    tbl.push_back(mk("tie_resp",  0, 0, 32'h0,   1, 32'h20, 1, 32'h55, 0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("wr1_grant", 0, 0, 32'h0,   1, 32'h20, 1, 32'h55, 0, 32'h0,        0, 0, 0, 1, 32'h20,  1, 32'h55, 32'h0));
    tbl.push_back(mk("wr1_ack",   0, 0, 32'h0,   1, 32'h20, 1, 32'h55, 1, 32'h9999,     0, 1, 0, 0, 32'h0,   0, 32'h0,  32'h0));
    tbl.push_back(mk("wr1_resp",  0, 0, 32'h0,   0, 32'h0,  0, 32'h0,  0, 32'h0,        0, 0, 0, 0, 32'h0,   0, 32'h0,  32'h0));

    foreach (tbl[i]) begin
      vec_t v;
      string tag;
      v = tbl[i];
      tag = $sformatf("v%0d_%s", i, v.name);
      reset = v.rst; i_req0 = v.req0; i_addr0 = v.addr0; i_req1 = v.req1;
      i_addr1 = v.addr1; i_we1 = v.we1; i_wdata1 = v.wdata1;
      i_memack = v.memack; i_memrdata = v.memrdata;
      step();
      check({tag, "_ack0"}, 32'(o_ack0), 32'(v.ack0));
      check({tag, "_ack1"}, 32'(o_ack1), 32'(v.ack1));
      check({tag, "_err"}, 32'(o_err), 32'(v.err));
      check({tag, "_memaccess"}, 32'(o_memaccess), 32'(v.memaccess));
      if (v.memaccess || v.rst) begin
        check({tag, "_memaddr"}, o_memaddr, v.memaddr);
        check({tag, "_memwe"}, 32'(o_memwe), 32'(v.memwe));
        check({tag, "_memwdata"}, o_memwdata, v.memwdata);
      end
      if (v.ack0 || v.ack1 || v.rst) check({tag, "_rdata"}, o_rdata, v.rdata);
    end
    reset = 1'b0; i_memack = 1'b0; i_we1 = 1'b0; i_wdata1 = '0;

    // Fairness: both ports request continuously for six grants.
    reset = 1'b1; step(); reset = 1'b0;
    i_req0 = 1'b1; i_addr0 = 32'h1000;
    i_req1 = 1'b1; i_addr1 = 32'h2000;
    for (int g = 0; g < 6; g++) begin
      logic [31:0] exp_addr;
      exp_addr = (g % 2 == 0) ? 32'h1000 : 32'h2000;
      wait_access($sformatf("fair%0d", g));
      check($sformatf("fair%0d_addr", g), o_memaddr, exp_addr);
      i_memack = 1'b1; i_memrdata = 32'hF000 + 32'(g);
      step();
      i_memack = 1'b0;
      check($sformatf("fair%0d_ack0", g), 32'(o_ack0), 32'(g % 2 == 0));
      check($sformatf("fair%0d_ack1", g), 32'(o_ack1), 32'(g % 2 == 1));
      check($sformatf("fair%0d_rdata", g), o_rdata, 32'hF000 + 32'(g));
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    step();

    // Timeout: memory never acks a port-1 read.
    begin
      int hi;
      i_req1 = 1'b1; i_addr1 = 32'h300;
      step();
      hi = o_memaccess ? 1 : 0;
      for (int k = 0; k < 20 && o_memaccess; k++) begin
        step();
        if (o_memaccess) hi++;
      end
      check("tmo_access_cycles", 32'(hi), 32'd4);
      check("tmo_ack1", 32'(o_ack1), 32'd1);
      check("tmo_ack0", 32'(o_ack0), 32'd0);
      check("tmo_err", 32'(o_err), 32'd1);
      check("tmo_rdata", o_rdata, 32'h0);
      i_req1 = 1'b0;
      step();
      check("tmo_err_clear", 32'(o_err), 32'd0);
      check("tmo_ack_clear", 32'(o_ack1), 32'd0);
      i_req0 = 1'b1; i_addr0 = 32'h400;
      step();
      check("post_tmo_access", 32'(o_memaccess), 32'd1);
      check("post_tmo_addr", o_memaddr, 32'h400);
      i_memack = 1'b1; i_memrdata = 32'h77;
      step();
      i_memack = 1'b0; i_req0 = 1'b0;
      check("post_tmo_ack0", 32'(o_ack0), 32'd1);
      check("post_tmo_err", 32'(o_err), 32'd0);
      check("post_tmo_rdata", o_rdata, 32'h77);
      step();
    end

    // Reset while BUSY: previous grant was port 0, so this tie goes to port 1.
    i_req0 = 1'b1; i_addr0 = 32'h500;
    i_req1 = 1'b1; i_addr1 = 32'h600; i_we1 = 1'b1; i_wdata1 = 32'hCAFE;
    step();
    check("rst_busy_addr", o_memaddr, 32'h600);
    check("rst_busy_access", 32'(o_memaccess), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_access", 32'(o_memaccess), 32'd0);
    check("rst_mid_addr", o_memaddr, 32'h0);
    check("rst_mid_we", 32'(o_memwe), 32'd0);
    check("rst_mid_wdata", o_memwdata, 32'h0);
    check("rst_mid_rdata", o_rdata, 32'h0);
    check("rst_mid_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
    check("rst_mid_err", 32'(o_err), 32'd0);
    i_memack = 1'b1; i_memrdata = 32'hBAD;
    step();
    i_memack = 1'b0;
    check("rst_late_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
    check("rst_tie_access", 32'(o_memaccess), 32'd1);
    check("rst_tie_addr", o_memaddr, 32'h500);
    check("rst_tie_we", 32'(o_memwe), 32'd0);
    step();
    i_memack = 1'b1; i_memrdata = 32'h1234_5678;
    step();
    i_memack = 1'b0; i_req0 = 1'b0;
    check("rst_tie_ack0", 32'(o_ack0), 32'd1);
    check("rst_tie_ack1", 32'(o_ack1), 32'd0);
    check("rst_tie_rdata", o_rdata, 32'h1234_5678);
    i_req1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
